// File: rtl/score_pkg.sv
// Shared types and constants for the numeric score field drawer.
package score_pkg;
  localparam logic [7:0] TRANSPARENT_ENCODING = 8'h00;
  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;

  typedef enum logic {IDLE, ADD} score_state_t;
  typedef logic [3:0] bcd_digit_t;

  function automatic logic in_rng(input logic [3:0] v, input logic [3:0] lo,
                                  input logic [3:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/digit_font.sv
// 16x16 one-bit glyphs for the decimal digits 0..9, built from seven
// two-pixel-thick bars; codes 10..15 are blank.
module digit_font
  import score_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       pixel
);
  logic [6:0] w_segs;
  logic [6:0] w_hit;

  // Bar order {a,b,c,d,e,f,g}: top, upper-right, lower-right, bottom,
  // lower-left, upper-left, middle.
  always_comb begin
    case (digit)
      4'd0:    w_segs = 7'h7E;
      4'd1:    w_segs = 7'h30;
      4'd2:    w_segs = 7'h6D;
      4'd3:    w_segs = 7'h79;
      4'd4:    w_segs = 7'h33;
      4'd5:    w_segs = 7'h5B;
      4'd6:    w_segs = 7'h5F;
      4'd7:    w_segs = 7'h70;
      4'd8:    w_segs = 7'h7F;
      4'd9:    w_segs = 7'h7B;
      default: w_segs = 7'h00;
    endcase
  end

  always_comb begin
    w_hit[6] = in_rng(row, 4'd1, 4'd2)   && in_rng(col, 4'd3, 4'd12);
    w_hit[5] = in_rng(col, 4'd11, 4'd12) && in_rng(row, 4'd1, 4'd7);
    w_hit[4] = in_rng(col, 4'd11, 4'd12) && in_rng(row, 4'd8, 4'd14);
    w_hit[3] = in_rng(row, 4'd13, 4'd14) && in_rng(col, 4'd3, 4'd12);
    w_hit[2] = in_rng(col, 4'd3, 4'd4)   && in_rng(row, 4'd8, 4'd14);
    w_hit[1] = in_rng(col, 4'd3, 4'd4)   && in_rng(row, 4'd1, 4'd7);
    w_hit[0] = in_rng(row, 4'd7, 4'd8)   && in_rng(col, 4'd3, 4'd12);
  end

  assign pixel = |(w_segs & w_hit);
endmodule

// File: rtl/score_digits.sv
// BCD score register with serial digit-per-clock adder and a frame-latched
// glyph renderer for the score field.
//   state | meaning
//   IDLE  | waiting for a point add; addReady high unless clearing
//   ADD   | adding carry into digit r_idx, one digit per clock
module score_digits
  import score_pkg::*;
#(
  parameter int         NUM_DIGITS  = 4,
  parameter int         TOP_LEFT_X  = 64,
  parameter int         TOP_LEFT_Y  = 0,
  parameter logic [7:0] DIGIT_COLOR = 8'hFF
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [10:0]             pixelX,
  input  logic [10:0]             pixelY,
  input  logic                    addValid,
  input  logic [3:0]              pointsValue,
  output logic                    addReady,
  input  logic                    clearScore,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow,
  output logic                    drawingRequest,
  output logic [7:0]              RGBout
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  score_state_t                  r_state, w_state_nxt;
  logic [2:0]                    r_idx, w_idx_nxt;
  logic [3:0]                    r_carry, w_carry_nxt;
  bcd_digit_t [NUM_DIGITS-1:0]   r_score, w_score_nxt;
  bcd_digit_t [NUM_DIGITS-1:0]   r_shadow;
  logic                          r_overflow, w_ovf_nxt;
  logic [7:0]                    r_rgb;
  bcd_digit_t                    w_cur;
  logic [4:0]                    w_sum;

  assign addReady  = (r_state == IDLE) && !clearScore;
  assign score_bcd = r_score;
  assign overflow  = r_overflow;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_carry_nxt = r_carry;
    w_score_nxt = r_score;
    w_ovf_nxt   = r_overflow;
    w_cur       = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r_idx == 3'(k)) w_cur = r_score[k];
    w_sum = {1'b0, w_cur} + {1'b0, r_carry};

    if (clearScore) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_carry_nxt = '0;
      w_score_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (addValid && addReady) begin
            w_carry_nxt = (pointsValue > 4'd9) ? 4'd9 : pointsValue;
            w_idx_nxt   = '0;
            w_state_nxt = ADD;
          end
        end
        ADD: begin
          for (int k = 0; k < NUM_DIGITS; k++)
            if (r_idx == 3'(k))
              w_score_nxt[k] = (w_sum > 5'd9) ? 4'(w_sum - 5'd10) : w_sum[3:0];
          w_carry_nxt = (w_sum > 5'd9) ? 4'd1 : 4'd0;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            // Carry out of the top digit saturates the whole field.
            if (w_sum > 5'd9) begin
              w_score_nxt = {NUM_DIGITS{4'd9}};
              w_ovf_nxt   = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_carry    <= '0;
      r_score    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_carry    <= w_carry_nxt;
      r_score    <= w_score_nxt;
      r_overflow <= w_ovf_nxt;
    end
  end

  // Pixel path: 12-bit differences wrap far above the field when left/above it.
  logic [11:0]         w_dx, w_dy;
  logic                w_inside;
  logic [2:0]          w_sel;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                w_zero_run;
  bcd_digit_t          w_glyph_digit;
  logic                w_glyph_blank;
  logic                w_font_px;

  assign w_dx     = {1'b0, pixelX} - 12'(TOP_LEFT_X);
  assign w_dy     = {1'b0, pixelY} - 12'(TOP_LEFT_Y);
  assign w_inside = (w_dx < 12'(GLYPH_W * NUM_DIGITS)) && (w_dy < 12'(GLYPH_H));
  assign w_sel    = LAST_IDX - w_dx[6:4];

  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run && (r_shadow[k] == 4'd0);
      w_blank[k] = w_zero_run;
    end
    w_glyph_digit = '0;
    w_glyph_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (w_sel == 3'(k)) begin
        w_glyph_digit = r_shadow[k];
        w_glyph_blank = w_blank[k];
      end
  end

  digit_font u_font (
    .digit (w_glyph_digit),
    .row   (w_dy[3:0]),
    .col   (w_dx[3:0]),
    .pixel (w_font_px)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_shadow <= '0;
      r_rgb    <= TRANSPARENT_ENCODING;
    end else begin
      if (startOfFrame) r_shadow <= r_score;
      r_rgb <= (w_inside && w_font_px && !w_glyph_blank) ? DIGIT_COLOR
                                                         : TRANSPARENT_ENCODING;
    end
  end

  assign RGBout         = r_rgb;
  assign drawingRequest = (r_rgb != TRANSPARENT_ENCODING);
endmodule

// File: tb/tb_score_digits.sv
// Directed bench for score_digits: handshake timing, BCD adds, saturation,
// clear/reset aborts, frame latching and the rendered pixel row.
module tb_score_digits;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = 11'd0;
  logic [10:0] pixelY = 11'd100;
  logic        addValid = 1'b0;
  logic [3:0]  pointsValue = 4'd0;
  logic        clearScore = 1'b0;
  logic        addReady, overflow, drawingRequest;
  logic [15:0] score_bcd;
  logic [7:0]  RGBout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_digits #(
    .NUM_DIGITS  (4),
    .TOP_LEFT_X  (64),
    .TOP_LEFT_Y  (0),
    .DIGIT_COLOR (8'hFF)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .addValid       (addValid),
    .pointsValue    (pointsValue),
    .addReady       (addReady),
    .clearScore     (clearScore),
    .score_bcd      (score_bcd),
    .overflow       (overflow),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an add and hold it until it is taken at a rising edge.
  task automatic accept(input logic [3:0] pts);
    int n;
    n = 0;
    @(negedge clk);
    addValid    = 1'b1;
    pointsValue = pts;
    while (addReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", addReady, 1'b1);
    @(posedge clk);
    #1 addValid = 1'b0;
  endtask

  // Busy for exactly four cycles after acceptance, then ready again.
  task automatic do_add(input logic [3:0] pts);
    accept(pts);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_ready_low", addReady, 1'b0);
    end
    @(negedge clk);
    check("ready_again", addReady, 1'b1);
  endtask

  task automatic pix(input int x, input logic [7:0] exp, input string tag);
    @(negedge clk);
    pixelX = 11'(x);
    @(posedge clk);
    #1;
    check(tag, RGBout, exp);
    check({tag, "_req"}, drawingRequest, exp != 8'h00);
  endtask

  initial begin
    #12;
    check("rst_score", score_bcd, 16'h0000);
    check("rst_overflow", overflow, 1'b0);
    check("rst_rgb", RGBout, 8'h00);
    check("rst_req", drawingRequest, 1'b0);
    check("rst_ready", addReady, 1'b1);
    @(negedge clk);
    resetN = 1'b1;

    do_add(4'd7);
    check("add7", score_bcd, 16'h0007);
    do_add(4'd5);
    check("add5", score_bcd, 16'h0012);

    // No frame start yet: field still shows the reset "0" in the rightmost cell.
    pixelY = 11'd10;
    pix(115, 8'hFF, "pre_sof_zero_left_bar");
    pix(123, 8'hFF, "pre_sof_zero_right_bar");
    pix(107, 8'h00, "pre_sof_no_one");

    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;

    // Row 10 of "  12": '1' lower-right bar at 107,108; '2' lower-left bar at 115,116.
    for (int x = 63; x <= 128; x++)
      pix(x, (x == 107 || x == 108 || x == 115 || x == 116) ? 8'hFF : 8'h00, "sweep_row10");

    // 12 + 9*1109 + 2 = 9995
    for (int i = 0; i < 1109; i++) do_add(4'd9);
    do_add(4'd2);
    check("preload_9995", score_bcd, 16'h9995);
    check("preload_no_ovf", overflow, 1'b0);
    do_add(4'd7);
    check("sat_score", score_bcd, 16'h9999);
    check("sat_overflow", overflow, 1'b1);
    do_add(4'd1);
    check("sat_hold_score", score_bcd, 16'h9999);
    check("sat_hold_overflow", overflow, 1'b1);

    @(negedge clk);
    clearScore  = 1'b1;
    addValid    = 1'b1;
    pointsValue = 4'd3;
    #1 check("clear_ready_low", addReady, 1'b0);
    @(posedge clk);
    #1;
    clearScore = 1'b0;
    addValid   = 1'b0;
    check("clear_score", score_bcd, 16'h0000);
    check("clear_overflow", overflow, 1'b0);
    repeat (6) @(negedge clk);
    check("clear_add_not_taken", score_bcd, 16'h0000);
    check("clear_ready", addReady, 1'b1);

    do_add(4'd15);
    check("clamp15", score_bcd, 16'h0009);

    // 9 + 9: digit 0 becomes 8 with a pending carry, then clear aborts.
    accept(4'd9);
    @(negedge clk);
    @(negedge clk);
    check("mid_add_digit0", score_bcd, 16'h0008);
    clearScore = 1'b1;
    @(posedge clk);
    #1 clearScore = 1'b0;
    @(negedge clk);
    check("mid_clear_score", score_bcd, 16'h0000);
    check("mid_clear_ready", addReady, 1'b1);
    repeat (4) @(negedge clk);
    check("mid_clear_no_resume", score_bcd, 16'h0000);
    do_add(4'd2);
    check("after_clear_add2", score_bcd, 16'h0002);

    // 2 + 9 mid-add reset: digit 0 already 1, then everything returns to reset.
    accept(4'd9);
    @(negedge clk);
    @(negedge clk);
    check("reset_pre_digit0", score_bcd, 16'h0001);
    resetN = 1'b0;
    #1;
    check("mid_reset_score", score_bcd, 16'h0000);
    check("mid_reset_ready", addReady, 1'b1);
    check("mid_reset_overflow", overflow, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    do_add(4'd3);
    check("after_reset_add3", score_bcd, 16'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
